// File: rtl/conv1_feed_ctrl.sv
// Purpose : streams one raster-order image frame from pixel memory into a 3x3 line buffer and counts the returned windows.
// Latency : a read issued in cycle t appears on pix_valid/pix_data in cycle t+2; done follows frame completion by one cycle.
// Backpr. : stall only withholds new memory reads; pixels already in the read pipeline are always delivered.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start               frame request, only honoured in IDLE
//   stall               downstream hold, suppresses new fetches in FETCH
//   mem_rd_en/mem_addr  pixel memory read strobe and raster-order address
//   mem_rdata           read data, valid the cycle after mem_rd_en
//   pix_valid/pix_data  pixel stream into the line buffer
//   win_valid           window strobe returned by the line buffer
//   win_cnt             windows counted in the current frame (saturates)
//   busy, done, err     FETCH/DRAIN indicator, frame-complete pulse, sticky error
module conv1_feed_ctrl #(
    parameter int WIDTH   = 28,
    parameter int HEIGHT  = 28,
    parameter int ADDR_W  = $clog2(WIDTH * HEIGHT),
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              pix_valid,
    output logic [7:0]        pix_data,
    input  logic              win_valid,
    output logic [9:0]        win_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                TMO_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [9:0]        N_WIN     = 10'((WIDTH - 2) * (HEIGHT - 2));
    localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rd_q;        // mem_rdata is valid this cycle
    logic [TMO_W-1:0] tmo;
    logic             accept;      // start taken in IDLE: frame initialisation
    logic             in_frame;
    logic             win_hit;
    logic             win_full;
    logic [9:0]       cnt_next;
    logic             tmo_hit;

    assign accept   = (state == IDLE) && start;
    assign in_frame = (state == FETCH) || (state == DRAIN);
    assign win_hit  = win_valid && in_frame;
    assign win_full = (win_cnt == N_WIN);
    // Count including this cycle's window, saturating at the expected total.
    assign cnt_next = (win_hit && !win_full) ? (win_cnt + 10'd1) : win_cnt;
    // Completion in the same cycle as the timeout takes priority over the error.
    assign tmo_hit  = (state == DRAIN) && (cnt_next != N_WIN) && (tmo == TMO_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_rd_en  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                mem_rd_en = !stall;
                if (!stall && (mem_addr == LAST_ADDR)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((cnt_next == N_WIN) || tmo_hit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            rd_q      <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= 8'd0;
            win_cnt   <= 10'd0;
            err       <= 1'b0;
            tmo       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Address stops on the last pixel rather than wrapping.
            if (accept) begin
                mem_addr <= '0;
            end else if (mem_rd_en && (mem_addr != LAST_ADDR)) begin
                mem_addr <= mem_addr + ADDR_W'(1);
            end

            // Two-stage read pipeline, independent of state and stall.
            rd_q      <= mem_rd_en;
            pix_valid <= rd_q;
            pix_data  <= rd_q ? mem_rdata : 8'd0;

            if (accept) begin
                win_cnt <= 10'd0;
            end else begin
                win_cnt <= cnt_next;
            end

            if (accept) begin
                err <= 1'b0;
            end else if ((win_hit && win_full) || tmo_hit) begin
                err <= 1'b1;
            end

            if (accept) begin
                tmo <= '0;
            end else if (state == DRAIN) begin
                tmo <= tmo + TMO_W'(1);
            end

            busy <= (state_next == FETCH) || (state_next == DRAIN);
            done <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_conv1_feed_ctrl.sv
// Purpose : drives directed frames into conv1_feed_ctrl with a pixel memory and line-buffer model attached.
// Latency : expected pixels and frame results are queued at stimulus time and checked when the DUT produces them.
// Backpr. : stall patterns are applied by the driver; the monitor is independent of them.
module tb_conv1_feed_ctrl;

    localparam int W    = 28;
    localparam int H    = 28;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);
    localparam int TMO  = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       win_valid;
    logic       mem_rd_en;
    logic [9:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic [9:0] win_cnt;
    logic       busy;
    logic       done;
    logic       err;

    conv1_feed_ctrl #(
        .WIDTH  (W),
        .HEIGHT (H),
        .ADDR_W (10),
        .TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stall    (stall),
        .mem_rd_en(mem_rd_en),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .win_valid(win_valid),
        .win_cnt  (win_cnt),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   delay;   // cycles from last read to done
        logic err;
        int   wcnt;
    } frame_t;

    frame_t     frame_q[$];
    logic [7:0] pix_q[$];
    int         rdc_q[$];
    logic [7:0] mem [NPIX];

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int wv_mode = 0;  // 0 normal buffer, 1 last window suppressed, 2 win_valid forced while busy

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Pixel memory: one-cycle read latency; junk value when not read.
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'hA5;

    // 3x3 line buffer model: a window completes on every pixel at row>=2, col>=2.
    int bcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt      <= 0;
            win_valid <= 1'b0;
        end else begin
            if (wv_mode == 2) win_valid <= busy;
            else win_valid <= pix_valid && (bcnt % W >= 2) && (bcnt / W >= 2)
                              && !(wv_mode == 1 && bcnt == NPIX - 1);
            if (start && !busy) bcnt <= 0;
            else if (pix_valid) bcnt <= bcnt + 1;
        end
    end

    // Monitor
    int     nrd = 0;
    int     npix = 0;
    int     last_rd = 0;
    logic   done_prev = 1'b0;
    frame_t fr;
    always @(negedge clk) begin
        if (!rst_n) begin
            nrd = 0;
            npix = 0;
            done_prev = 1'b0;
        end else begin
            if (done_prev) chk("done_one_cycle", done, 0);
            if (mem_rd_en) begin
                chk("rd_addr_order", mem_addr, nrd);
                rdc_q.push_back(cyc);
                nrd++;
                last_rd = cyc;
            end
            if (pix_valid) begin
                npix++;
                chk("pix_expected", int'(pix_q.size() > 0 && rdc_q.size() > 0), 1);
                if (pix_q.size() > 0 && rdc_q.size() > 0) begin
                    chk("pix_latency", cyc - rdc_q.pop_front(), 2);
                    chk("pix_data", pix_data, pix_q.pop_front());
                end
            end
            if (done) begin
                chk("done_expected", int'(frame_q.size() > 0), 1);
                if (frame_q.size() > 0) begin
                    fr = frame_q.pop_front();
                    chk("done_delay", cyc - last_rd, fr.delay);
                    chk("frame_err", err, fr.err);
                    chk("frame_win_cnt", win_cnt, fr.wcnt);
                    chk("busy_at_done", busy, 0);
                    chk("frame_reads", nrd, NPIX);
                    chk("frame_pixels", npix, NPIX);
                end
                nrd = 0;
                npix = 0;
            end
            done_prev = done;
        end
    end

    task automatic queue_frame(input int dly, input logic e, input int wc);
        frame_t f;
        for (int i = 0; i < NPIX; i++) pix_q.push_back(mem[i]);
        f.delay = dly;
        f.err   = e;
        f.wcnt  = wc;
        frame_q.push_back(f);
    endtask

    task automatic run_frame(input int mode, input int dly, input logic e, input int wc,
                             input logic stall_pat, input int restart_at);
        int   k;
        logic got;
        wv_mode = mode;
        queue_frame(dly, e, wc);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        got = 1'b0;
        while (!got && k < 3000) begin
            stall = stall_pat && (k % 3 == 2);
            start = (restart_at >= 0) && (int'(mem_addr) == restart_at) && busy;
            @(negedge clk);
            k++;
            if (done) got = 1'b1;
        end
        stall = 1'b0;
        start = 1'b0;
        chk("frame_finished", got, 1);
        @(negedge clk);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        int   k;
        logic any;
        for (int i = 0; i < NPIX; i++) mem[i] = 8'((i * 7 + 3) % 256);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_win_cnt", win_cnt, 0);
        chk("rst_busy_done_err", {busy, done, err}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean frame, no stall
        run_frame(0, 4, 1'b0, NWIN, 1'b0, -1);
        // Stall every third cycle
        run_frame(0, 4, 1'b0, NWIN, 1'b1, -1);
        // Last window never returned: timeout after TMO+1 drain cycles
        run_frame(1, TMO + 2, 1'b1, NWIN - 1, 1'b0, -1);
        // Start re-pulsed at address 300 is ignored; err from previous frame cleared
        run_frame(0, 4, 1'b0, NWIN, 1'b0, 300);
        // Surplus windows: err set, count saturates, drain finishes immediately
        run_frame(2, 2, 1'b1, NWIN, 1'b0, -1);

        // Reset mid-frame at address 500
        wv_mode = 0;
        queue_frame(4, 1'b0, NWIN);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (mem_addr != 10'd500 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("reach_addr_500", mem_addr, 500);
        rst_n = 1'b0;
        pix_q.delete();
        frame_q.delete();
        rdc_q.delete();
        #1;
        chk("midrst_mem_rd_en", mem_rd_en, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_pix", {pix_valid, pix_data}, 0);
        chk("midrst_win_cnt", win_cnt, 0);
        chk("midrst_busy_done_err", {busy, done, err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        any = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any = any | mem_rd_en | busy | pix_valid | done;
        end
        chk("no_activity_after_reset", any, 0);

        // Clean frame after reset starts from address 0
        run_frame(0, 4, 1'b0, NWIN, 1'b0, -1);

        repeat (4) @(negedge clk);
        chk("pix_queue_drained", pix_q.size(), 0);
        chk("frame_queue_drained", frame_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/conv1_feed_ctrl.md
CONV1_FEED_CTRL -- requirements
Module: conv1_feed_ctrl

Interface
REQ-001 Parameter WIDTH, default 28, image columns.
REQ-002 Parameter HEIGHT, default 28, image rows.
REQ-003 Parameter ADDR_W, default $clog2(WIDTH*HEIGHT) (10), pixel memory address width.
REQ-004 Parameter TIMEOUT, default 15, max DRAIN cycles without frame completion.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  frame request; sampled only in IDLE.
REQ-008 stall  in  1  downstream hold; suppresses new pixel fetches.
REQ-009 mem_rd_en  out  1  pixel memory read strobe.
REQ-010 mem_addr  out  ADDR_W  pixel memory address, raster order.
REQ-011 mem_rdata  in  8  read data; valid exactly 1 cycle after a mem_rd_en cycle.
REQ-012 pix_valid  out  1  pixel strobe to the 3x3 line buffer valid input.
REQ-013 pix_data  out  8  pixel to the line buffer.
REQ-014 win_valid  in  1  window-valid strobe returned by the line buffer.
REQ-015 win_cnt  out  10  windows counted in the current frame.
REQ-016 busy  out  1  high in FETCH and DRAIN.
REQ-017 done  out  1  one-cycle frame-complete pulse.
REQ-018 err  out  1  sticky timeout flag; cleared on next accepted start.

Function
REQ-019 FSM states IDLE, FETCH, DRAIN, DONE; reset state IDLE.
REQ-020 IDLE: start=1 -> FETCH next cycle; mem_addr<=0, win_cnt<=0, err<=0, timeout counter<=0.
REQ-021 FETCH: stall=0 -> mem_rd_en=1 with current mem_addr, then mem_addr increments; stall=1 -> mem_rd_en=0, mem_addr holds.
REQ-022 FETCH: read issued at address WIDTH*HEIGHT-1 -> DRAIN next cycle; mem_addr holds at that last value (no wrap) until next start.
REQ-023 mem_rd_en combinational from state and stall; no read outside FETCH.
REQ-024 pix_valid = mem_rd_en registered 1 cycle; pix_data = mem_rdata registered on that strobe, else 0; fixed 2-cycle latency from read issue to pix_valid.
REQ-025 Exactly WIDTH*HEIGHT pix_valid pulses per frame regardless of stall pattern; no duplicates or drops.
REQ-026 win_cnt increments on each win_valid cycle in FETCH or DRAIN; win_valid ignored in IDLE and DONE.
REQ-027 Expected windows N_WIN = (WIDTH-2)*(HEIGHT-2) = 676 at defaults.
REQ-028 DRAIN: win_cnt reaches N_WIN (including increment this cycle) -> DONE.
REQ-029 DRAIN: timeout counter increments each cycle; reaching TIMEOUT without completion -> err<=1, DONE.
REQ-030 DONE: done=1 for exactly one cycle, then IDLE; win_cnt holds until next accepted start.
REQ-031 start while busy or in DONE ignored, no effect on sequencing.
REQ-032 stall in IDLE, DRAIN or DONE has no effect; stall never delays pix_valid already in flight.
REQ-033 win_valid after win_cnt = N_WIN in same frame: err<=1, win_cnt saturates at N_WIN.
REQ-034 busy is a registered decode of state; done is a registered decode of state DONE.

Reset
REQ-035 rst_n=0 at any time incl. mid-frame -> immediately IDLE; mem_rd_en=0, mem_addr=0, pix_valid=0, pix_data=0, win_cnt=0, busy=0, done=0, err=0, timeout counter=0.
REQ-036 After reset release no activity until a new start.

Verification
REQ-037 start pulse, stall=0, buffer model attached -> 784 consecutive pix_valid, first 2 cycles after first mem_rd_en; win_cnt=676; done one cycle; busy low after.
REQ-038 stall=1 every 3rd cycle during FETCH -> 784 pix_valid in address order 0..783, pix_data matches memory image, win_cnt=676, err=0.
REQ-039 win_valid held low after the last pixel -> done asserted TIMEOUT+1 cycles after DRAIN entry, err=1, win_cnt less than 676.
REQ-040 start re-pulsed at address 300 mid-FETCH -> ignored, single frame, exactly 784 reads.
REQ-041 rst_n low at mem_addr=500 -> all outputs 0 same edge; later start -> complete clean frame from address 0.
REQ-042 extra win_valid injected after count 676 -> err=1, win_cnt stays 676.
